// File: rtl/sap_mem_pkg.sv
// Shared definitions for the SAP RAM controller: default geometry,
// request opcode encodings and the controller state encoding.
package sap_mem_pkg;

  // Default RAM geometry: 16 locations of 8 bits.
  localparam int DEF_ADDR_BITS = 4;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_RAM_BYTES = 16;

  // Request opcodes carried on req_op.
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } sap_op_e;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RESP     = 3'd4,
    ST_FILL     = 3'd5
  } sap_state_e;

endpackage

// File: rtl/sap_ram_controller.sv
// Bus initiator for the SAP-style DFF RAM. Turns read/write/fill requests
// into registered mem_mar/mem_wdata/mem_lr_n/mem_ce_n strobes and returns
// read data through a valid/ready response port.
module sap_ram_controller
  import sap_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int RAM_BYTES = DEF_RAM_BYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] mem_mar,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_lr_n,
  output logic                 mem_ce_n,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  // Last address swept by a fill; the counter wraps to 0 explicitly here.
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_BYTES - 1);

  sap_state_e           state_reg, state_next;
  logic [ADDR_BITS-1:0] mar_reg, mar_next;
  logic [ADDR_BITS-1:0] cnt_reg, cnt_next;
  logic [DATA_BITS-1:0] wdata_reg, wdata_next;
  logic [DATA_BITS-1:0] rdata_reg, rdata_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic                 lr_n_reg, ce_n_reg;
  logic                 accept;
  sap_op_e              op;

  assign op        = sap_op_e'(req_op);
  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign accept    = req_valid & req_ready;

  assign mem_mar   = mar_reg;
  assign mem_wdata = wdata_reg;
  assign mem_lr_n  = lr_n_reg;
  assign mem_ce_n  = ce_n_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;

  // State and datapath registers; strobes are decoded from the next state so
  // they are registered and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mar_reg       <= '0;
      cnt_reg       <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      lr_n_reg      <= 1'b1;
      ce_n_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      mar_reg       <= mar_next;
      cnt_reg       <= cnt_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      rsp_valid_reg <= rsp_valid_next;
      lr_n_reg      <= !((state_next == ST_WRITE) || (state_next == ST_FILL));
      ce_n_reg      <= (state_next != ST_RD_ISSUE);
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_READ:  state_next = ST_RD_ISSUE;
            OP_WRITE: state_next = ST_WRITE;
            OP_FILL:  state_next = ST_FILL;
            default:  state_next = ST_IDLE;  // reserved op is swallowed
          endcase
        end
      end
      ST_WRITE:    state_next = ST_IDLE;
      ST_RD_ISSUE: state_next = ST_RD_CAPT;
      ST_RD_CAPT:  state_next = ST_RESP;
      ST_RESP:     if (rsp_ready) state_next = ST_IDLE;
      ST_FILL:     if (cnt_reg == LAST_ADDR) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Datapath updates: address/data/counter/response; everything holds by
  // default so mem_mar and mem_wdata keep their last values while idle.
  always_comb begin
    mar_next       = mar_reg;
    cnt_next       = cnt_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    rsp_valid_next = rsp_valid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_READ: begin
              mar_next = req_addr;
            end
            OP_WRITE: begin
              mar_next   = req_addr;
              wdata_next = req_wdata;
            end
            OP_FILL: begin
              mar_next   = '0;
              cnt_next   = '0;
              wdata_next = req_wdata;
            end
            default: ;
          endcase
        end
      end
      ST_RD_CAPT: begin
        // RAM output was registered on the previous edge and is valid now.
        rdata_next     = mem_rdata;
        rsp_valid_next = 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) rsp_valid_next = 1'b0;
      end
      ST_FILL: begin
        if (cnt_reg == LAST_ADDR) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_BITS'(1);
          mar_next = cnt_reg + ADDR_BITS'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sap_ram_controller.sv
// Directed bench for sap_ram_controller with a behavioural model of the
// 16x8 SAP DFF RAM attached to the memory strobes.
module tb_sap_ram_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [3:0] req_addr = 4'h0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [3:0] mem_mar;
  logic [7:0] mem_wdata;
  logic       mem_lr_n;
  logic       mem_ce_n;
  logic [7:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  logic ram_clr = 1'b0;
  logic [7:0] ram [16];

  always #5 clk = ~clk;

  sap_ram_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mem_mar   (mem_mar),
    .mem_wdata (mem_wdata),
    .mem_lr_n  (mem_lr_n),
    .mem_ce_n  (mem_ce_n),
    .mem_rdata (mem_rdata)
  );

  // RAM model: samples mar/data/strobes on clk, registered read data.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (!mem_lr_n) ram[mem_mar] <= mem_wdata;
      if (!mem_ce_n) mem_rdata <= ram[mem_mar];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobes must never both be active.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(mem_lr_n === 1'b0 && mem_ce_n === 1'b0)) else begin
        failures++;
        $error("FAIL strobe_overlap observed=lr_n%0b_ce_n%0b expected=not_both_0", mem_lr_n, mem_ce_n);
      end
    end
  end

  // Single write, called from a negedge; returns at a negedge with DUT idle.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_op = 2'b01; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_lr_n", mem_lr_n, 1'b0);
    check("wr_mar", mem_mar, a);
    check("wr_wdata", mem_wdata, d);
    @(negedge clk);
    check("wr_lr_n_end", mem_lr_n, 1'b1);
    check("wr_idle", req_ready, 1'b1);
    $display("write addr=%0h data=%0h", a, d);
  endtask

  // Read with rsp_ready held low for 'hold' extra RESP cycles.
  task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input int hold);
    req_valid = 1'b1; req_op = 2'b00; req_addr = a; req_wdata = 8'h00;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_issue_ce_n", mem_ce_n, 1'b0);
    check("rd_issue_mar", mem_mar, a);
    check("rd_issue_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check("rd_capt_ce_n", mem_ce_n, 1'b1);
    check("rd_capt_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_rdata", rsp_rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rd_hold_valid", rsp_valid, 1'b1);
      check("rd_hold_rdata", rsp_rdata, exp);
      check("rd_hold_req_ready", req_ready, 1'b0);
      check("rd_hold_ce_n", mem_ce_n, 1'b1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_done_valid", rsp_valid, 1'b0);
    check("rd_done_req_ready", req_ready, 1'b1);
    $display("read addr=%0h data=%0h expected=%0h hold=%0d", a, rsp_rdata, exp, hold);
  endtask

  initial begin
    // Reset state and RAM model clear.
    ram_clr = 1'b1;
    repeat (3) @(negedge clk);
    ram_clr = 1'b0;
    check("rst_lr_n", mem_lr_n, 1'b1);
    check("rst_ce_n", mem_ce_n, 1'b1);
    check("rst_mar", mem_mar, 4'h0);
    check("rst_wdata", mem_wdata, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    $display("reset state checked");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset asserted during cycle 7 of a 0x55 fill.
    req_valid = 1'b1; req_op = 2'b10; req_addr = 4'h0; req_wdata = 8'h55;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check("abort_mar", mem_mar, 4'h6);
    rst_n = 1'b0;
    #1;
    check("abort_lr_n", mem_lr_n, 1'b1);
    check("abort_ce_n", mem_ce_n, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_req_ready", req_ready, 1'b1);
    @(negedge clk);
    check("abort_ram0", ram[0], 8'h55);
    for (int i = 7; i < 16; i++) check("abort_ram_untouched", ram[i], 8'h00);
    $display("fill aborted by reset at cycle 7");
    rst_n = 1'b1;
    @(negedge clk);

    // 2: write then read back.
    do_write(4'h3, 8'hA5);
    do_read(4'h3, 8'hA5, 0);

    // 3: full fill with 0x3C.
    req_valid = 1'b1; req_op = 2'b10; req_addr = 4'h9; req_wdata = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("fill_lr_n", mem_lr_n, 1'b0);
      check("fill_mar", mem_mar, i);
      check("fill_wdata", mem_wdata, 8'h3C);
      check("fill_busy", busy, 1'b1);
    end
    @(negedge clk);
    check("fill_end_lr_n", mem_lr_n, 1'b1);
    check("fill_end_busy", busy, 1'b0);
    $display("fill value=3c done");
    do_read(4'h0, 8'h3C, 0);
    do_read(4'hF, 8'h3C, 0);

    // 4: read with stalled response consumer.
    do_write(4'h9, 8'h81);
    do_read(4'h9, 8'h81, 5);

    // 5: reserved op is dropped.
    do_write(4'h2, 8'h42);
    req_valid = 1'b1; req_op = 2'b11; req_addr = 4'h2; req_wdata = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    check("rsvd_lr_n", mem_lr_n, 1'b1);
    check("rsvd_ce_n", mem_ce_n, 1'b1);
    check("rsvd_req_ready", req_ready, 1'b1);
    check("rsvd_busy", busy, 1'b0);
    check("rsvd_wdata_hold", mem_wdata, 8'h42);
    check("rsvd_rsp_valid", rsp_valid, 1'b0);
    $display("reserved op dropped");
    do_read(4'h2, 8'h42, 0);

    // 6: back-to-back writes with req_valid held high.
    req_valid = 1'b1; req_op = 2'b01; req_addr = 4'h0; req_wdata = 8'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_lr_n", mem_lr_n, 1'b0);
      check("b2b_mar", mem_mar, k);
      check("b2b_wdata", mem_wdata, 8'h10 + k);
      check("b2b_req_ready", req_ready, 1'b0);
      if (k == 2) req_valid = 1'b0;
      req_addr = 4'(k + 1);
      req_wdata = 8'h11 + 8'(k);
      @(negedge clk);
      check("b2b_lr_n_gap", mem_lr_n, 1'b1);
      check("b2b_req_ready_gap", req_ready, 1'b1);
      $display("b2b write %0d accepted", k);
    end
    do_read(4'h0, 8'h10, 0);
    do_read(4'h1, 8'h11, 0);
    do_read(4'h2, 8'h12, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
